alarm_scheduler: RTL and testbench
==================================

Name: alarm_scheduler

Overview:
Multi-slot alarm controller that sits between the RTC time bus and the alarm output/buzzer logic.
- Holds N programmable alarm slots.
- Scans them sequentially once per RTC second change.
- Sequences the ring / acknowledge / snooze / timeout lifecycle.
- Drives a single alarm_active output plus the index of the slot that fired.

Parameters:
N_SLOTS, 4, number of alarm slots
IDX_W, 2, slot index width (N_SLOTS <= 2**IDX_W)
RING_SECS, 30, seconds an unacknowledged alarm rings before auto-stop
SNOOZE_MIN, 5, snooze delay in minutes (1..59)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
hour_rtc  in  5  RTC hour, 0..23
min_rtc  in  6  RTC minute, 0..59
sec_rtc  in  6  RTC second, 0..59
cfg_we  in  1  write strobe for one slot
cfg_idx  in  IDX_W  slot written
cfg_en  in  1  slot enable bit written
cfg_hour  in  5  slot hour
cfg_min  in  6  slot minute
cfg_sec  in  6  slot second
btn_ack  in  1  acknowledge/stop (single-cycle pulse, already debounced)
btn_snooze  in  1  snooze request (single-cycle pulse)
alarm_active  out  1  alarm ringing
active_slot  out  IDX_W  slot currently/last ringing
snooze_pending  out  1  a snooze re-fire is armed
missed_pulse  out  1  one-cycle pulse on ring timeout
busy  out  1  high while in SCAN

Behaviour:
- Reset (rst=0, async): state=IDLE; all slots disabled with time 0:00:00; prev_sec=0; ring_cnt=0; snooze cleared. All outputs 0.
- Second tick: tick=1 in any cycle where sec_rtc != prev_sec; prev_sec updates in the same cycle.
- FSM states: IDLE, SCAN, RING.
- IDLE:
  - On tick: snapshot hour/min/sec, idx=0, go SCAN.
  - btn_ack in IDLE clears snooze_pending.
- SCAN: one slot compared per cycle, idx 0..N_SLOTS-1; busy=1. A slot matches when enabled and all three fields equal the snapshot.
  - Snooze check: in the first SCAN cycle, the snapshot is compared against the snooze target. A snooze match has priority: ring with active_slot=snooze slot; snooze_pending clears.
  - Slot match: the first matching slot (lowest index) wins. Next cycle: RING, alarm_active=1, active_slot=idx, ring_cnt=0.
  - No match after the last slot: back to IDLE.
  - Latency: a match on slot k asserts alarm_active k+1 cycles after the tick.
  - Ticks occurring during SCAN are dropped (clk >> N_SLOTS Hz makes this unreachable in use).
- RING:
  - alarm_active=1.
  - Each tick increments ring_cnt; slots are not scanned, so alarms due while ringing are lost.
  - btn_ack: next cycle alarm_active=0, go IDLE.
  - btn_snooze: compute target = snapshot + SNOOZE_MIN minutes, same seconds.
    - Minute wraps at 60 with carry into hour; hour wraps 23->0.
    - Store the target and the ringing slot; set snooze_pending=1; alarm_active=0; go IDLE.
    - A new snooze overwrites any older pending one.
  - btn_ack and btn_snooze in the same cycle: ack wins, no snooze.
  - ring_cnt reaching RING_SECS: alarm_active=0, missed_pulse=1 for one cycle, go IDLE, snooze unchanged.
- Config writes:
  - Accepted in every state; take effect the following cycle.
  - A slot compared in the same cycle uses its old value.
  - Disabling the ringing slot does not stop the ring.
  - cfg_idx >= N_SLOTS is ignored.
- active_slot holds its value after the ring ends until the next ring.
- Async reset mid-RING or mid-SCAN: immediate return to reset values.

Test Plan:
1. Program slot 2 = 07:30:00 enabled; RTC steps 07:29:59 -> 07:30:00 -> alarm_active rises 3 cycles after the tick, active_slot=2, busy high for exactly 3 cycles.
2. Slots 1 and 3 both = 12:00:00 enabled, slot 0 same time disabled -> active_slot=1; btn_ack -> alarm_active=0 the next cycle.
3. Ringing at 23:58:10, btn_snooze with SNOOZE_MIN=5 -> snooze_pending=1; at RTC 00:03:10 ring restarts with the original slot and snooze_pending=0; no ring at 00:03:09.
4. Ring left unacknowledged with RING_SECS=30 -> exactly 30 ticks later alarm_active=0 and missed_pulse is high for one cycle; a second alarm set for tick 10 of the ring never fires.
5. btn_ack and btn_snooze asserted together while ringing -> alarm_active=0, snooze_pending stays 0.
6. Drive rst=0 asynchronously mid-RING (between clock edges) -> alarm_active=0 immediately; after release, previously programmed times no longer fire.

Source files
------------

// File: rtl/alarm_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_scheduler
//   Multi-slot alarm controller sitting between the RTC time bus and the
//   buzzer logic. N_SLOTS programmable alarm slots are scanned one per cycle
//   after every RTC second change. The block then sequences the ring,
//   acknowledge, snooze and ring-timeout lifecycle.
//
// Ports
//   clk, rst          system clock, asynchronous active-low reset
//   hour/min/sec_rtc  current RTC time (0..23 / 0..59 / 0..59)
//   cfg_*             single-slot configuration write (cfg_we strobe)
//   btn_ack           stop a ringing alarm / cancel a pending snooze (pulse)
//   btn_snooze        re-arm the ringing alarm SNOOZE_MIN minutes later (pulse)
//   alarm_active      alarm is ringing
//   active_slot       slot currently (or most recently) ringing
//   snooze_pending    a snooze re-fire is armed
//   missed_pulse      one-cycle pulse when a ring times out unacknowledged
//   busy              slot scan in progress
// -----------------------------------------------------------------------------
module alarm_scheduler #(
  parameter int N_SLOTS    = 4,
  parameter int IDX_W      = 2,
  parameter int RING_SECS  = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       hour_rtc,
  input  logic [5:0]       min_rtc,
  input  logic [5:0]       sec_rtc,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [4:0]       cfg_hour,
  input  logic [5:0]       cfg_min,
  input  logic [5:0]       cfg_sec,
  input  logic             btn_ack,
  input  logic             btn_snooze,
  output logic             alarm_active,
  output logic [IDX_W-1:0] active_slot,
  output logic             snooze_pending,
  output logic             missed_pulse,
  output logic             busy
);

  // ring_cnt only has to hold 0..RING_SECS-1; the tick that would reach
  // RING_SECS ends the ring instead of being stored.
  localparam int CNT_W = (RING_SECS < 2) ? 1 : $clog2(RING_SECS);
  localparam int IW1   = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RING_SECS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RING = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [5:0]         prev_sec_q, prev_sec_d;
  logic [4:0]         snap_hour_q, snap_hour_d;
  logic [5:0]         snap_min_q, snap_min_d;
  logic [5:0]         snap_sec_q, snap_sec_d;
  logic [CNT_W-1:0]   ring_cnt_q, ring_cnt_d;
  logic               snz_pend_q, snz_pend_d;
  logic [4:0]         snz_hour_q, snz_hour_d;
  logic [5:0]         snz_min_q, snz_min_d;
  logic [5:0]         snz_sec_q, snz_sec_d;
  logic [IDX_W-1:0]   snz_slot_q, snz_slot_d;
  logic [IDX_W-1:0]   act_slot_q, act_slot_d;
  logic               missed_q, missed_d;

  logic [N_SLOTS-1:0] slot_en_q, slot_en_d;
  logic [4:0]         slot_hour_q [N_SLOTS];
  logic [4:0]         slot_hour_d [N_SLOTS];
  logic [5:0]         slot_min_q  [N_SLOTS];
  logic [5:0]         slot_min_d  [N_SLOTS];
  logic [5:0]         slot_sec_q  [N_SLOTS];
  logic [5:0]         slot_sec_d  [N_SLOTS];

  logic               tick;
  logic               cfg_idx_ok;
  logic               slot_hit;
  logic               snz_hit;
  logic [6:0]         min_sum;
  logic [4:0]         tgt_hour;
  logic [5:0]         tgt_min;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    tick       = (sec_rtc != prev_sec_q);
    cfg_idx_ok = ({1'b0, cfg_idx} < IW1'(N_SLOTS));

    slot_hit = slot_en_q[idx_q]
            && (slot_hour_q[idx_q] == snap_hour_q)
            && (slot_min_q[idx_q]  == snap_min_q)
            && (slot_sec_q[idx_q]  == snap_sec_q);

    snz_hit = snz_pend_q
           && (snz_hour_q == snap_hour_q)
           && (snz_min_q  == snap_min_q)
           && (snz_sec_q  == snap_sec_q);

    // Snooze target: snapshot + SNOOZE_MIN minutes, minute carry into hour,
    // hour wraps 23 -> 0. Seconds are carried over unchanged.
    min_sum  = {1'b0, snap_min_q} + 7'(SNOOZE_MIN);
    tgt_min  = snap_min_q;
    tgt_hour = snap_hour_q;
    if (min_sum >= 7'd60) begin
      tgt_min  = 6'(min_sum - 7'd60);
      tgt_hour = (snap_hour_q == 5'd23) ? 5'd0 : snap_hour_q + 5'd1;
    end else begin
      tgt_min  = min_sum[5:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    prev_sec_d  = sec_rtc;
    snap_hour_d = snap_hour_q;
    snap_min_d  = snap_min_q;
    snap_sec_d  = snap_sec_q;
    ring_cnt_d  = ring_cnt_q;
    snz_pend_d  = snz_pend_q;
    snz_hour_d  = snz_hour_q;
    snz_min_d   = snz_min_q;
    snz_sec_d   = snz_sec_q;
    snz_slot_d  = snz_slot_q;
    act_slot_d  = act_slot_q;
    missed_d    = 1'b0;
    slot_en_d   = slot_en_q;
    slot_hour_d = slot_hour_q;
    slot_min_d  = slot_min_q;
    slot_sec_d  = slot_sec_q;

    // Writes land at the clock edge, so a slot being compared this cycle
    // still sees its old contents.
    if (cfg_we && cfg_idx_ok) begin
      slot_en_d[cfg_idx]   = cfg_en;
      slot_hour_d[cfg_idx] = cfg_hour;
      slot_min_d[cfg_idx]  = cfg_min;
      slot_sec_d[cfg_idx]  = cfg_sec;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (btn_ack) begin
          snz_pend_d = 1'b0;
        end
        if (tick) begin
          snap_hour_d = hour_rtc;
          snap_min_d  = min_rtc;
          snap_sec_d  = sec_rtc;
          idx_d       = '0;
          state_d     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // The snooze target is only examined alongside slot 0 and beats any
        // slot match found in that cycle.
        if ((idx_q == '0) && snz_hit) begin
          state_d    = ST_RING;
          act_slot_d = snz_slot_q;
          snz_pend_d = 1'b0;
          ring_cnt_d = '0;
        end else if (slot_hit) begin
          state_d    = ST_RING;
          act_slot_d = idx_q;
          ring_cnt_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_RING: begin
        // Priority: acknowledge, then snooze, then timeout.
        if (btn_ack) begin
          state_d = ST_IDLE;
        end else if (btn_snooze) begin
          snz_pend_d = 1'b1;
          snz_hour_d = tgt_hour;
          snz_min_d  = tgt_min;
          snz_sec_d  = snap_sec_q;
          snz_slot_d = act_slot_q;
          state_d    = ST_IDLE;
        end else if (tick) begin
          if (ring_cnt_q == CNT_LAST) begin
            missed_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      prev_sec_q  <= '0;
      snap_hour_q <= '0;
      snap_min_q  <= '0;
      snap_sec_q  <= '0;
      ring_cnt_q  <= '0;
      snz_pend_q  <= 1'b0;
      snz_hour_q  <= '0;
      snz_min_q   <= '0;
      snz_sec_q   <= '0;
      snz_slot_q  <= '0;
      act_slot_q  <= '0;
      missed_q    <= 1'b0;
      slot_en_q   <= '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        slot_hour_q[i] <= '0;
        slot_min_q[i]  <= '0;
        slot_sec_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      prev_sec_q  <= prev_sec_d;
      snap_hour_q <= snap_hour_d;
      snap_min_q  <= snap_min_d;
      snap_sec_q  <= snap_sec_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_pend_q  <= snz_pend_d;
      snz_hour_q  <= snz_hour_d;
      snz_min_q   <= snz_min_d;
      snz_sec_q   <= snz_sec_d;
      snz_slot_q  <= snz_slot_d;
      act_slot_q  <= act_slot_d;
      missed_q    <= missed_d;
      slot_en_q   <= slot_en_d;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        slot_hour_q[i] <= slot_hour_d[i];
        slot_min_q[i]  <= slot_min_d[i];
        slot_sec_q[i]  <= slot_sec_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    alarm_active   = (state_q == ST_RING);
    busy           = (state_q == ST_SCAN);
    active_slot    = act_slot_q;
    snooze_pending = snz_pend_q;
    missed_pulse   = missed_q;
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alarm_scheduler
//   Directed scenarios followed by a randomized phase. Expected outputs come
//   from a reference model that decides the outcome of each scan at the
//   moment of the second tick (times held as seconds-of-day integers) and
//   then only counts down the scan latency.
// -----------------------------------------------------------------------------
module tb_alarm_scheduler;

  localparam int N_SLOTS    = 4;
  localparam int IDX_W      = 2;
  localparam int RING_SECS  = 30;
  localparam int SNOOZE_MIN = 5;
  localparam int DAY        = 86400;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       hour_rtc;
  logic [5:0]       min_rtc;
  logic [5:0]       sec_rtc;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_en;
  logic [4:0]       cfg_hour;
  logic [5:0]       cfg_min;
  logic [5:0]       cfg_sec;
  logic             btn_ack;
  logic             btn_snooze;
  logic             alarm_active;
  logic [IDX_W-1:0] active_slot;
  logic             snooze_pending;
  logic             missed_pulse;
  logic             busy;

  always #5 clk = ~clk;

  alarm_scheduler #(
    .N_SLOTS    (N_SLOTS),
    .IDX_W      (IDX_W),
    .RING_SECS  (RING_SECS),
    .SNOOZE_MIN (SNOOZE_MIN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hour_rtc       (hour_rtc),
    .min_rtc        (min_rtc),
    .sec_rtc        (sec_rtc),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_en         (cfg_en),
    .cfg_hour       (cfg_hour),
    .cfg_min        (cfg_min),
    .cfg_sec        (cfg_sec),
    .btn_ack        (btn_ack),
    .btn_snooze     (btn_snooze),
    .alarm_active   (alarm_active),
    .active_slot    (active_slot),
    .snooze_pending (snooze_pending),
    .missed_pulse   (missed_pulse),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = scanning, 2 = ringing
  int m_mode;
  int m_prev_sec;
  int m_cnt;
  int m_win;
  bit m_from_snz;
  int m_snap;
  int m_ring_ticks;
  int m_snz_t;
  int m_snz_slot;
  bit m_en [N_SLOTS];
  int m_t  [N_SLOTS];
  int e_slot;
  bit e_snz;
  bit e_missed;

  int tod;
  int pool [4];

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mode       = 0;
    m_prev_sec   = 0;
    m_cnt        = 0;
    m_win        = -1;
    m_from_snz   = 1'b0;
    m_snap       = 0;
    m_ring_ticks = 0;
    m_snz_t      = 0;
    m_snz_slot   = 0;
    e_slot       = 0;
    e_snz        = 1'b0;
    e_missed     = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      m_en[k] = 1'b0;
      m_t[k]  = 0;
    end
  endtask

  task automatic model_step();
    int  t_now;
    bit  tk;
    t_now = hms(int'(hour_rtc), int'(min_rtc), int'(sec_rtc));
    tk = (int'(sec_rtc) != m_prev_sec);
    m_prev_sec = int'(sec_rtc);
    e_missed = 1'b0;
    case (m_mode)
      0: begin
        if (btn_ack) e_snz = 1'b0;
        if (tk) begin
          m_snap = t_now;
          if (e_snz && t_now == m_snz_t) begin
            m_win      = m_snz_slot;
            m_from_snz = 1'b1;
            m_cnt      = 1;
          end else begin
            m_win      = -1;
            m_from_snz = 1'b0;
            for (int k = 0; k < N_SLOTS; k++)
              if (m_win < 0 && m_en[k] && m_t[k] == t_now) m_win = k;
            m_cnt = (m_win < 0) ? N_SLOTS : m_win + 1;
          end
          m_mode = 1;
        end
      end
      1: begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_win >= 0) begin
            m_mode       = 2;
            e_slot       = m_win;
            m_ring_ticks = 0;
            if (m_from_snz) e_snz = 1'b0;
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
        if (btn_ack) begin
          m_mode = 0;
        end else if (btn_snooze) begin
          m_snz_t    = (m_snap + SNOOZE_MIN * 60) % DAY;
          m_snz_slot = e_slot;
          e_snz      = 1'b1;
          m_mode     = 0;
        end else if (tk) begin
          m_ring_ticks++;
          if (m_ring_ticks == RING_SECS) begin
            m_mode   = 0;
            e_missed = 1'b1;
          end
        end
      end
    endcase
    if (cfg_we && int'(cfg_idx) < N_SLOTS) begin
      m_en[int'(cfg_idx)] = cfg_en;
      m_t[int'(cfg_idx)]  = hms(int'(cfg_hour), int'(cfg_min), int'(cfg_sec));
    end
  endtask

  task automatic set_tod(input int t);
    hour_rtc = 5'(t / 3600);
    min_rtc  = 6'((t / 60) % 60);
    sec_rtc  = 6'(t % 60);
  endtask

  // One clock: model advances on the same edge as the DUT, outputs sampled
  // 1 time unit later, then single-cycle inputs drop.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("active",  32'(alarm_active),   32'(m_mode == 2));
    check("busy",    32'(busy),           32'(m_mode == 1));
    check("slot",    32'(active_slot),    32'(e_slot));
    check("snooze",  32'(snooze_pending), 32'(e_snz));
    check("missed",  32'(missed_pulse),   32'(e_missed));
    btn_ack    = 1'b0;
    btn_snooze = 1'b0;
    cfg_we     = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic write_slot(input int idx, input bit en, input int t);
    cfg_we   = 1'b1;
    cfg_idx  = IDX_W'(idx);
    cfg_en   = en;
    cfg_hour = 5'(t / 3600);
    cfg_min  = 6'((t / 60) % 60);
    cfg_sec  = 6'(t % 60);
    cyc();
  endtask

  task automatic goto(input int t);
    tod = t;
    set_tod(t);
    cyc();
  endtask

  initial begin
    int  rise;
    int  busy_cnt;
    int  r;
    int  s;
    int  nt;
    bit  tk;

    pool[0] = hms(8, 0, 0);
    pool[1] = hms(23, 59, 58);
    pool[2] = 100;
    pool[3] = hms(12, 30, 0);

    rst        = 1'b0;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_en     = 1'b0;
    cfg_hour   = '0;
    cfg_min    = '0;
    cfg_sec    = '0;
    btn_ack    = 1'b0;
    btn_snooze = 1'b0;
    tod        = 0;
    set_tod(0);
    m_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_active",  32'(alarm_active),   32'(0));
    check("rst_busy",    32'(busy),           32'(0));
    check("rst_slot",    32'(active_slot),    32'(0));
    check("rst_snooze",  32'(snooze_pending), 32'(0));
    check("rst_missed",  32'(missed_pulse),   32'(0));
    rst = 1'b1;

    // 1: slot 2 at 07:30:00, latency and busy width
    write_slot(2, 1'b1, hms(7, 30, 0));
    goto(hms(7, 29, 59));
    run(6);
    goto(hms(7, 30, 0));
    busy_cnt = int'(busy);
    rise = -1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      busy_cnt += int'(busy);
      if (rise < 0 && alarm_active) rise = c;
    end
    check("t1_rise_latency", 32'(rise),        32'(3));
    check("t1_busy_cycles",  32'(busy_cnt),    32'(3));
    check("t1_slot",         32'(active_slot), 32'(2));
    btn_ack = 1'b1;
    cyc();

    // 2: lowest enabled matching slot wins, ack stops next cycle
    write_slot(0, 1'b0, hms(12, 0, 0));
    write_slot(1, 1'b1, hms(12, 0, 0));
    write_slot(3, 1'b1, hms(12, 0, 0));
    goto(hms(11, 59, 59));
    run(6);
    goto(hms(12, 0, 0));
    run(6);
    check("t2_active", 32'(alarm_active), 32'(1));
    check("t2_slot",   32'(active_slot),  32'(1));
    btn_ack = 1'b1;
    cyc();
    check("t2_ack_off", 32'(alarm_active), 32'(0));

    // 3: snooze across midnight
    write_slot(3, 1'b1, hms(23, 58, 10));
    goto(hms(23, 58, 9));
    run(6);
    goto(hms(23, 58, 10));
    run(6);
    check("t3_ring_slot", 32'(active_slot), 32'(3));
    btn_snooze = 1'b1;
    cyc();
    check("t3_pending", 32'(snooze_pending), 32'(1));
    check("t3_stopped", 32'(alarm_active),   32'(0));
    goto(hms(0, 3, 9));
    run(6);
    check("t3_early_quiet", 32'(alarm_active), 32'(0));
    goto(hms(0, 3, 10));
    run(3);
    check("t3_refire",         32'(alarm_active),   32'(1));
    check("t3_refire_slot",    32'(active_slot),    32'(3));
    check("t3_pending_clears", 32'(snooze_pending), 32'(0));
    btn_ack = 1'b1;
    cyc();

    // 4: ring timeout after RING_SECS ticks; alarm due mid-ring is lost
    write_slot(0, 1'b1, hms(10, 0, 0));
    write_slot(2, 1'b1, hms(10, 0, 10));
    goto(hms(9, 59, 59));
    run(6);
    goto(hms(10, 0, 0));
    run(4);
    check("t4_ringing", 32'(alarm_active), 32'(1));
    for (int i = 1; i <= RING_SECS; i++) begin
      goto(hms(10, 0, 0) + i);
      if (i == RING_SECS) begin
        check("t4_timeout_off", 32'(alarm_active), 32'(0));
        check("t4_missed_hi",   32'(missed_pulse), 32'(1));
      end else begin
        check("t4_still_ring",  32'(alarm_active), 32'(1));
        check("t4_slot_held",   32'(active_slot),  32'(0));
      end
      run(2);
    end
    check("t4_missed_once", 32'(missed_pulse), 32'(0));
    check("t4_no_late",     32'(alarm_active), 32'(0));

    // 5: ack and snooze together
    write_slot(1, 1'b1, hms(13, 0, 0));
    goto(hms(12, 59, 59));
    run(6);
    goto(hms(13, 0, 0));
    run(6);
    check("t5_ringing", 32'(alarm_active), 32'(1));
    btn_ack    = 1'b1;
    btn_snooze = 1'b1;
    cyc();
    check("t5_off",        32'(alarm_active),   32'(0));
    check("t5_no_snooze",  32'(snooze_pending), 32'(0));

    // 6: asynchronous reset mid-ring
    write_slot(2, 1'b1, hms(14, 0, 0));
    goto(hms(13, 59, 59));
    run(6);
    goto(hms(14, 0, 0));
    run(6);
    check("t6_ringing", 32'(alarm_active), 32'(1));
    #3 rst = 1'b0;
    #1;
    check("t6_async_off",  32'(alarm_active), 32'(0));
    check("t6_async_slot", 32'(active_slot),  32'(0));
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    goto(hms(13, 59, 59));
    run(6);
    goto(hms(14, 0, 0));
    run(6);
    check("t6_forgotten", 32'(alarm_active), 32'(0));

    // Randomized phase
    for (int it = 0; it < 3000; it++) begin
      nt = tod;
      r = int'($urandom_range(0, 99));
      if (r < 25) begin
        s = int'($urandom_range(0, 9));
        if (s < 4)      nt = (tod + 1) % DAY;
        else if (s < 8) nt = pool[$urandom_range(0, 3)] - int'($urandom_range(0, 1));
        else            nt = e_snz ? m_snz_t : (tod + 1) % DAY;
      end
      tk = ((nt % 60) != (tod % 60));
      tod = nt;
      set_tod(tod);
      if (!tk && m_mode != 1 && $urandom_range(0, 99) < 8) begin
        nt       = pool[$urandom_range(0, 3)];
        cfg_we   = 1'b1;
        cfg_idx  = IDX_W'($urandom_range(0, N_SLOTS - 1));
        cfg_en   = 1'($urandom_range(0, 1));
        cfg_hour = 5'(nt / 3600);
        cfg_min  = 6'((nt / 60) % 60);
        cfg_sec  = 6'(nt % 60);
      end
      btn_ack    = ($urandom_range(0, 99) < 2);
      btn_snooze = ($urandom_range(0, 99) < 2);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
